// File: rtl/alu_issue_station.sv
// ALU reservation station: holds dispatched ops until A, B and NZCV are ready,
// snoops the FU result broadcast for wakeup, and issues one ready op per cycle.
package alu_issue_pkg;
  localparam int GPR_SIZE     = 32;
  localparam int ROB_IDX_SIZE = 5;

  typedef enum logic [3:0] {
    ALU_PLUS  = 4'd0,
    ALU_MINUS = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SHL   = 4'd5,
    ALU_SHR   = 4'd6,
    ALU_MOV   = 4'd7
  } alu_op_t;

  typedef logic [3:0] nzcv_t;
endpackage

module alu_issue_station
  import alu_issue_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_flush,
  input  logic                    in_dispatch_valid,
  input  alu_op_t                 in_dispatch_op,
  input  logic                    in_dispatch_a_ready,
  input  logic [GPR_SIZE-1:0]     in_dispatch_a,
  input  logic                    in_dispatch_b_ready,
  input  logic [GPR_SIZE-1:0]     in_dispatch_b,
  input  logic                    in_dispatch_nzcv_ready,
  input  nzcv_t                   in_dispatch_nzcv,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_tag,
  input  logic                    in_dispatch_set_nzcv,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
  input  logic                    in_fu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
  input  logic [GPR_SIZE-1:0]     in_fu_value,
  input  logic                    in_fu_set_nzcv,
  input  nzcv_t                   in_fu_nzcv,
  input  logic                    in_fu_alu_ready,
  output logic                    out_full,
  output logic [$clog2(RS_SIZE):0] out_count,
  output logic                    out_alu_start,
  output alu_op_t                 out_alu_op,
  output logic [GPR_SIZE-1:0]     out_alu_val_a,
  output logic [GPR_SIZE-1:0]     out_alu_val_b,
  output logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index,
  output logic                    out_alu_set_nzcv,
  output nzcv_t                   out_alu_nzcv
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]      valid_r, a_rdy_r, b_rdy_r, f_rdy_r, set_nzcv_r;
  alu_op_t                 op_r     [RS_SIZE];
  logic [GPR_SIZE-1:0]     a_r      [RS_SIZE];
  logic [GPR_SIZE-1:0]     b_r      [RS_SIZE];
  nzcv_t                   f_r      [RS_SIZE];
  logic [ROB_IDX_SIZE-1:0] f_tag_r  [RS_SIZE];
  logic [ROB_IDX_SIZE-1:0] dst_r    [RS_SIZE];
  logic [CNT_W-1:0]        count_r;
  logic                    full_r;

  logic [RS_SIZE-1:0]  ready_s;
  logic [IDX_W-1:0]    free_idx_s, sel_idx_s;
  logic                has_free_s, has_sel_s, accept_s, issue_s;
  logic                a_hit_s, b_hit_s, f_hit_s;
  logic                disp_a_rdy_s, disp_b_rdy_s, disp_f_rdy_s;
  logic [GPR_SIZE-1:0] disp_a_s, disp_b_s;
  nzcv_t               disp_f_s;
  logic [CNT_W-1:0]    count_nxt_s;

  // Lowest free slot and lowest fully-ready entry, iterated high to low so the lowest wins.
  always_comb begin
    ready_s    = valid_r & a_rdy_r & b_rdy_r & f_rdy_r;
    free_idx_s = '0;
    has_free_s = 1'b0;
    sel_idx_s  = '0;
    has_sel_s  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : IDX_W'(i);
      has_free_s = has_free_s | ~valid_r[i];
      sel_idx_s  = ready_s[i] ? IDX_W'(i) : sel_idx_s;
      has_sel_s  = has_sel_s | ready_s[i];
    end
  end

  // Dispatch operands with same-cycle broadcast bypass, plus handshake and count bookkeeping.
  always_comb begin
    a_hit_s      = in_fu_done && (in_dispatch_a[ROB_IDX_SIZE-1:0] == in_fu_dst_rob_index);
    b_hit_s      = in_fu_done && (in_dispatch_b[ROB_IDX_SIZE-1:0] == in_fu_dst_rob_index);
    f_hit_s      = in_fu_done && in_fu_set_nzcv && (in_dispatch_nzcv_tag == in_fu_dst_rob_index);
    disp_a_rdy_s = in_dispatch_a_ready | a_hit_s;
    disp_b_rdy_s = in_dispatch_b_ready | b_hit_s;
    disp_f_rdy_s = in_dispatch_nzcv_ready | f_hit_s;
    disp_a_s     = (!in_dispatch_a_ready && a_hit_s) ? in_fu_value : in_dispatch_a;
    disp_b_s     = (!in_dispatch_b_ready && b_hit_s) ? in_fu_value : in_dispatch_b;
    disp_f_s     = (!in_dispatch_nzcv_ready && f_hit_s) ? in_fu_nzcv : in_dispatch_nzcv;
    accept_s     = in_dispatch_valid && !full_r && has_free_s;
    issue_s      = in_fu_alu_ready && has_sel_s;
    count_nxt_s  = count_r + CNT_W'(accept_s) - CNT_W'(issue_s);
  end

  // Entry storage: dispatch write, issue invalidate, and tag-match wakeup.
  always_ff @(posedge in_clk) begin
    if (in_rst || in_flush) begin
      valid_r    <= '0;
      a_rdy_r    <= '0;
      b_rdy_r    <= '0;
      f_rdy_r    <= '0;
      set_nzcv_r <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_r[i]    <= ALU_PLUS;
        a_r[i]     <= '0;
        b_r[i]     <= '0;
        f_r[i]     <= '0;
        f_tag_r[i] <= '0;
        dst_r[i]   <= '0;
      end
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(RS_SIZE));
      for (int i = 0; i < RS_SIZE; i++) begin
        if (accept_s && (free_idx_s == IDX_W'(i))) begin
          valid_r[i]    <= 1'b1;
          op_r[i]       <= in_dispatch_op;
          a_rdy_r[i]    <= disp_a_rdy_s;
          a_r[i]        <= disp_a_s;
          b_rdy_r[i]    <= disp_b_rdy_s;
          b_r[i]        <= disp_b_s;
          f_rdy_r[i]    <= disp_f_rdy_s;
          f_r[i]        <= disp_f_s;
          f_tag_r[i]    <= in_dispatch_nzcv_tag;
          set_nzcv_r[i] <= in_dispatch_set_nzcv;
          dst_r[i]      <= in_dispatch_dst_rob_index;
        end else begin
          if (issue_s && (sel_idx_s == IDX_W'(i))) begin
            valid_r[i] <= 1'b0;
          end
          if (valid_r[i] && in_fu_done) begin
            if (!a_rdy_r[i] && (a_r[i][ROB_IDX_SIZE-1:0] == in_fu_dst_rob_index)) begin
              a_r[i]     <= in_fu_value;
              a_rdy_r[i] <= 1'b1;
            end
            if (!b_rdy_r[i] && (b_r[i][ROB_IDX_SIZE-1:0] == in_fu_dst_rob_index)) begin
              b_r[i]     <= in_fu_value;
              b_rdy_r[i] <= 1'b1;
            end
            if (!f_rdy_r[i] && in_fu_set_nzcv && (f_tag_r[i] == in_fu_dst_rob_index)) begin
              f_r[i]     <= in_fu_nzcv;
              f_rdy_r[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Issue bundle register: loads the selected entry, otherwise holds with start low.
  always_ff @(posedge in_clk) begin
    if (in_rst || in_flush) begin
      out_alu_start         <= 1'b0;
      out_alu_op            <= ALU_PLUS;
      out_alu_val_a         <= '0;
      out_alu_val_b         <= '0;
      out_alu_dst_rob_index <= '0;
      out_alu_set_nzcv      <= 1'b0;
      out_alu_nzcv          <= '0;
    end else if (issue_s) begin
      out_alu_start         <= 1'b1;
      out_alu_op            <= op_r[sel_idx_s];
      out_alu_val_a         <= a_r[sel_idx_s];
      out_alu_val_b         <= b_r[sel_idx_s];
      out_alu_dst_rob_index <= dst_r[sel_idx_s];
      out_alu_set_nzcv      <= set_nzcv_r[sel_idx_s];
      out_alu_nzcv          <= f_r[sel_idx_s];
    end else begin
      out_alu_start <= 1'b0;
    end
  end

  assign out_full  = full_r;
  assign out_count = count_r;
endmodule
